ls_sch_seq: RTL and testbench
=============================

# ls_sch_seq

Sequencer for the linear-search memory datapath: on `start` it walks an address range of the shared synchronous RAM one word at a time, compares each word with a search key, and reports the first matching address. It also arbitrates the RAM between the search engine and a host port. The host gets the RAM only at safe yield points, and the search resumes afterwards without losing position. It drives the RAM address/enable and the `sel_adr` mux select in front of the RAM.

## Interface
- `A`, 8, address width
- `D`, 8, data width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle search request
- `sch_adr1`  in  A  range bound 1
- `sch_adr2`  in  A  range bound 2
- `key`  in  D  search key, sampled with `start`
- `mem_rdata`  in  D  RAM read data, valid the cycle after `mem_ce`
- `host_req`  in  1  host requests the RAM
- `host_gnt`  out  1  host owns the RAM (registered)
- `mem_ce`  out  1  RAM chip enable for search reads
- `mem_we`  out  1  RAM write enable from the search side, constant 0
- `mem_adr`  out  A  search read address
- `sel_adr`  out  1  RAM mux select: 1 = search side, 0 = host side
- `busy`  out  1  search accepted and not yet finished
- `done`  out  1  one-cycle completion pulse
- `found`  out  1  match flag, held until next accepted `start`
- `found_adr`  out  A  first matching address, held with `found`

## Operation
- States: IDLE, PEND, RD, CMP, HOLD, DONE.
- Start acceptance:
  - `start` is accepted only in IDLE.
  - On acceptance, latch `str = min(sch_adr1, sch_adr2)`, `end = max(...)`, `cur = str`, and `key`.
  - On acceptance, clear `found` and `found_adr`, and set `busy`.
  - Next state is RD if `host_req = 0`, otherwise PEND.
  - `start` in any other state is ignored.
- PEND:
  - `host_gnt = 1`, `sel_adr = 0`.
  - Go to RD on the first sampled `host_req = 0`.
- RD:
  - `mem_ce = 1`, `mem_adr = cur`, `sel_adr = 1`.
  - Always go to CMP; a read in flight is never preempted.
- CMP, evaluated in this order:
  - If `mem_rdata == key`: `found <= 1`, `found_adr <= cur`, go to DONE.
  - Else if `cur == end`: go to DONE with `found = 0`.
  - Else: `cur <= cur + 1`, then go to HOLD if `host_req = 1`, otherwise RD.
- HOLD:
  - `host_gnt = 1`, `sel_adr = 0`, `mem_ce = 0`.
  - Go to RD on sampled `host_req = 0`; `cur` is preserved.
- DONE: `done = 1` for one cycle, `busy <= 0`, go to IDLE.
- IDLE:
  - `host_gnt` follows `host_req` with one cycle of delay.
  - `sel_adr = 0` whenever `host_gnt = 1`.
- Width rules:
  - `cur` is A bits.
  - The `cur == end` test precedes the increment, so `cur` never wraps. The full range 0..2^A-1 reads 2^A words.
- `sch_adr1 == sch_adr2` reads exactly one word.
- `sch_adr1 > sch_adr2` is legal because the bounds are swapped at acceptance.
- Bounds and `key` are not re-sampled mid-search.
- Reset, asynchronous at any time including mid-search:
  - State goes to IDLE.
  - All outputs go to 0: `host_gnt`, `mem_ce`, `mem_we`, `mem_adr`, `sel_adr`, `busy`, `done`, `found`, `found_adr`.
  - Any in-flight read is abandoned.

## Timing
- Cycle 0: `start` is sampled at the end of cycle 0.
  - Cycle 1 is RD at `str`; cycle 2 is CMP; `busy = 1` from cycle 1.
- Each word costs 2 cycles (RD + CMP).
- Match at offset k with no host activity: `done` pulses in cycle 3+2k. `found` and `found_adr` are valid in the same cycle.
- No match over N words: `done` in cycle 1+2N.
- Host latency:
  - `host_gnt` rises at most 2 cycles after `host_req` rises during a search (finishing RD→CMP, then HOLD).
  - In IDLE, `host_gnt` rises 1 cycle after `host_req`.
  - `host_gnt` falls 1 cycle after `host_req` falls; RD follows in that same cycle.
- `host_req` during CMP of the final word does not enter HOLD. The search goes to DONE, and the grant is given from IDLE.
- `sel_adr` and `host_gnt` are never both 1. `mem_ce = 1` implies `sel_adr = 1`.

## Test plan
- RAM[i] = i, bounds 0x10/0x20, key 0x14, start → RD addresses 0x10..0x14; `done` at cycle 11; `found = 1`, `found_adr = 0x14`.
- Bounds 0x20/0x10 (swapped), key 0xFF absent → 17 reads 0x10..0x20; `done` at cycle 35; `found = 0`.
- Bounds 0x00/0xFF, key absent → 256 reads, no address wrap; `done` at cycle 513; `busy` is high through cycle 512.
- Key 0x14 at 0x14, `host_req` pulsed high for 5 cycles starting at cycle 3 → HOLD, with `host_gnt` high and `sel_adr` and `mem_ce` low. The search then resumes at the preserved address and returns `found_adr = 0x14`; every address is read exactly once.
- `start` while busy → ignored. `start` with `host_req = 1` in IDLE → PEND; RD begins the cycle after `host_req` drops.
- `rst_n` low during CMP → all outputs 0 immediately. A new `start` after release runs a clean search with correct results.

Source files
------------

// File: rtl/ls_sch_seq.sv
// Linear-search sequencer: walks [min,max] of a synchronous RAM looking for a key,
// yielding the RAM to a host port only between words (PEND/HOLD) and resuming in place.
module ls_sch_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] sch_adr1,
    input  logic [ADDR_W-1:0] sch_adr2,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              host_req,
    output logic              host_gnt,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              sel_adr,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] found_adr
);

    typedef enum logic [2:0] {IDLE, PEND, RD, CMP, HOLD, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur, end_adr;
    logic [DATA_W-1:0] key_q;
    logic              accept, hit, last;

    assign accept = (state == IDLE) && start;
    assign hit    = (mem_rdata == key_q);
    assign last   = (cur == end_adr);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = host_req ? PEND : RD;
            PEND: if (!host_req) state_nxt = RD;
            RD:   state_nxt = CMP;
            CMP: begin
                if (hit || last) state_nxt = DONE;
                else             state_nxt = host_req ? HOLD : RD;
            end
            HOLD: if (!host_req) state_nxt = RD;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant is registered off the next state so it lines up with PEND/HOLD exactly
    // and trails host_req by one cycle while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            host_gnt  <= 1'b0;
            busy      <= 1'b0;
            found     <= 1'b0;
            found_adr <= '0;
        end else begin
            state    <= state_nxt;
            host_gnt <= (state_nxt == PEND) || (state_nxt == HOLD) ||
                        ((state_nxt == IDLE) && host_req);
            if (accept) begin
                busy      <= 1'b1;
                found     <= 1'b0;
                found_adr <= '0;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
            if ((state == CMP) && hit) begin
                found     <= 1'b1;
                found_adr <= cur;
            end
        end
    end

    // Range and key are captured once per search; the end test precedes the
    // increment so cur never wraps past the top of the address space.
    always_ff @(posedge clk) begin
        if (accept) begin
            cur     <= (sch_adr1 < sch_adr2) ? sch_adr1 : sch_adr2;
            end_adr <= (sch_adr1 < sch_adr2) ? sch_adr2 : sch_adr1;
            key_q   <= key;
        end else if ((state == CMP) && !hit && !last) begin
            cur <= cur + ADDR_W'(1);
        end
    end

    assign mem_ce  = (state == RD);
    assign mem_we  = 1'b0;
    assign mem_adr = mem_ce ? cur : '0;
    assign sel_adr = (state == RD) || (state == CMP);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_ls_sch_seq.sv
// Bench for ls_sch_seq: synchronous RAM model, table vectors, host-yield and
// reset sequences, and randomized searches against a range-scan reference.
module tb_ls_sch_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] sch_adr1 = '0, sch_adr2 = '0, key = '0;
    logic [7:0] mem_rdata = '0;
    logic       host_req = 1'b0;
    logic       host_gnt, mem_ce, mem_we, sel_adr, busy, done, found;
    logic [7:0] mem_adr, found_adr;

    ls_sch_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sch_adr1(sch_adr1), .sch_adr2(sch_adr2),
        .key(key), .mem_rdata(mem_rdata), .host_req(host_req), .host_gnt(host_gnt),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_adr(mem_adr), .sel_adr(sel_adr),
        .busy(busy), .done(done), .found(found), .found_adr(found_adr)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [256];
    logic [7:0] reads [$];
    int checks = 0, failures = 0, inv_err = 0;

    always @(posedge clk) if (mem_ce) mem_rdata <= ram[mem_adr];

    always @(negedge clk) begin
        if (rst_n && mem_ce) reads.push_back(mem_adr);
        if (sel_adr && host_gnt) inv_err++;
        if (mem_ce && !sel_adr) inv_err++;
        if (mem_we) inv_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: scan the swapped range in order, stop at the first equal word.
    task automatic model(input logic [7:0] a, b, k, output bit f, output logic [7:0] adr,
                         output int n, output int lo);
        int hi;
        lo = (a < b) ? int'(a) : int'(b);
        hi = (a < b) ? int'(b) : int'(a);
        f = 0; adr = '0; n = hi - lo + 1;
        for (int i = lo; i <= hi; i++)
            if (ram[i] == k) begin f = 1; adr = 8'(i); n = i - lo + 1; break; end
    endtask

    // hmode: 0 no host, 1 host_req high for cycles [hfrom, hfrom+hlen), 2 random host_req
    task automatic run(input logic [7:0] a, b, k, input int hmode, input int hfrom,
                       input int hlen, input bit busy_start,
                       output int done_cyc, output int gnt_cnt, output int busy_gap);
        int cyc;
        reads.delete();
        @(posedge clk); #1;
        sch_adr1 = a; sch_adr2 = b; key = k; start = 1'b1;
        host_req = (hmode == 1) && (hfrom == 0) && (hlen > 0);
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        done_cyc = -1; gnt_cnt = 0; busy_gap = 0;
        while (cyc < 3000) begin
            case (hmode)
                1: host_req = (cyc >= hfrom) && (cyc < hfrom + hlen);
                2: host_req = ($urandom_range(0, 3) == 0);
                default: host_req = 1'b0;
            endcase
            if (busy_start && cyc == 4) begin
                start = 1'b1; sch_adr1 = 8'h00; sch_adr2 = 8'h00; key = 8'h00;
            end else start = 1'b0;
            if (host_gnt) gnt_cnt++;
            if (done) begin done_cyc = cyc; break; end
            if (!busy) busy_gap++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        host_req = 1'b0;
    endtask

    task automatic chk_reads(input string tag, input int lo, input int n);
        int bad = -1;
        chk({tag, "_nreads"}, reads.size(), n);
        for (int i = 0; i < reads.size() && i < n; i++)
            if (reads[i] != 8'(lo + i) && bad < 0) bad = i;
        chk({tag, "_read_seq_first_bad"}, bad, -1);
    endtask

    typedef struct {
        logic [7:0] a, b, k;
        bit         f;
        logic [7:0] adr;
        int         dcyc, nreads;
        bit         bstart;
    } vec_t;

    vec_t vt [8];

    initial begin
        int dc, gc, bg, lo, n;
        bit f;
        logic [7:0] adr;

        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        ram[255] = 8'h00;

        vt[0] = '{8'h10, 8'h20, 8'h14, 1, 8'h14, 11, 5, 0};
        vt[1] = '{8'h20, 8'h10, 8'hFF, 0, 8'h00, 35, 17, 0};
        vt[2] = '{8'h00, 8'hFF, 8'hFF, 0, 8'h00, 513, 256, 0};
        vt[3] = '{8'h30, 8'h30, 8'h30, 1, 8'h30, 3, 1, 0};
        vt[4] = '{8'h30, 8'h30, 8'h31, 0, 8'h00, 3, 1, 0};
        vt[5] = '{8'hFE, 8'hFF, 8'h00, 1, 8'hFF, 5, 2, 0};
        vt[6] = '{8'h05, 8'h00, 8'h00, 1, 8'h00, 3, 1, 0};
        vt[7] = '{8'h10, 8'h20, 8'h14, 1, 8'h14, 11, 5, 1};

        #3;
        chk("reset_outputs", {host_gnt, mem_ce, mem_we, mem_adr, sel_adr, busy, done, found, found_adr}, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            run(vt[v].a, vt[v].b, vt[v].k, 0, 0, 0, vt[v].bstart, dc, gc, bg);
            chk({tag, "_done_cycle"}, dc, vt[v].dcyc);
            chk({tag, "_found"}, found, vt[v].f);
            chk({tag, "_found_adr"}, found_adr, vt[v].adr);
            chk({tag, "_busy_gap"}, bg, 0);
            chk_reads(tag, (vt[v].a < vt[v].b) ? vt[v].a : vt[v].b, vt[v].nreads);
            @(posedge clk); #1;
            chk({tag, "_found_held"}, {found, found_adr, busy, done}, {vt[v].f, vt[v].adr, 2'b00});
        end

        // Host window mid-search: HOLD from cycle 5 to 8, resume at 0x12.
        run(8'h10, 8'h20, 8'h14, 1, 3, 5, 0, dc, gc, bg);
        chk("hold_done_cycle", dc, 15);
        chk("hold_gnt_cycles", gc, 4);
        chk("hold_found_adr", {found, found_adr}, {1'b1, 8'h14});
        chk_reads("hold", 8'h10, 5);

        // Host grant in IDLE, then start while host holds the RAM -> PEND.
        @(posedge clk); #1; host_req = 1'b1;
        @(posedge clk); #1;
        chk("idle_gnt_follow", {host_gnt, sel_adr}, 2'b10);
        run(8'h10, 8'h20, 8'h14, 1, 0, 3, 0, dc, gc, bg);
        chk("pend_done_cycle", dc, 14);
        chk("pend_gnt_cycles", gc, 3);
        chk_reads("pend", 8'h10, 5);
        @(posedge clk); #1;
        chk("idle_gnt_drop", host_gnt, 0);

        // Asynchronous reset during CMP, then a clean search.
        @(posedge clk); #1;
        sch_adr1 = 8'h10; sch_adr2 = 8'h20; key = 8'h14; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy_sel", {busy, sel_adr}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {host_gnt, mem_ce, mem_we, mem_adr, sel_adr, busy, done, found, found_adr}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        run(8'h10, 8'h20, 8'h14, 0, 0, 0, 0, dc, gc, bg);
        chk("post_rst_done_cycle", dc, 11);
        chk("post_rst_found_adr", {found, found_adr}, {1'b1, 8'h14});
        chk_reads("post_rst", 8'h10, 5);

        // Randomized searches against the reference scan.
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom_range(0, 47));
        for (int t = 0; t < 20; t++) begin
            logic [7:0] a, b, k;
            int hm;
            string tag;
            tag = $sformatf("rnd%0d", t);
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            k = 8'($urandom_range(0, 63));
            hm = (t % 2 == 0) ? 0 : 2;
            model(a, b, k, f, adr, n, lo);
            run(a, b, k, hm, 0, 0, 0, dc, gc, bg);
            chk({tag, "_found"}, {found, found_adr}, {f, adr});
            chk({tag, "_terminated"}, dc > 0, 1);
            if (hm == 0) chk({tag, "_done_cycle"}, dc, f ? (1 + 2 * n) : (1 + 2 * n));
            chk_reads(tag, lo, n);
            repeat (2) @(posedge clk);
        end

        chk("invariants", inv_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
